// File: rtl/instr_load_pkg.sv
// Shared widths, lane mapping and queue entry layout
// for the narrow-to-wide stream packers.
package instr_load_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int RATIO_DEF = 4;

  function automatic int out_w(
    input int in_w,
    input int ratio
  );
    return in_w * ratio;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The mapping is its own inverse: lane -> beat
  // uses the same call as beat -> lane.
  function automatic int lane_idx(
    input int k,
    input int ratio,
    input bit lsb_first
  );
    return lsb_first ? k : ratio - 1 - k;
  endfunction

  typedef struct packed {
    logic [out_w(IN_W_DEF, RATIO_DEF)-1:0] data;
    logic [RATIO_DEF-1:0]                  keep;
  } entry_t;

endpackage

// File: rtl/word_assembler_if.sv
// Beat input / word output handshake bundle
// of the word assembler.
interface word_assembler_if
  import instr_load_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);

  localparam int OUT_W = out_w(IN_W, RATIO);
  localparam int CW    = cnt_w(RATIO);

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [OUT_W-1:0] out_data;
  logic [RATIO-1:0] out_keep;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    lane_cnt;

  modport master (
    output in_data,
    output in_valid,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_keep,
    input  out_valid,
    input  lane_cnt
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_keep,
    output out_valid,
    output lane_cnt
  );

endinterface

// File: rtl/word_fifo.sv
// Synchronous DEPTH-entry FIFO with an occupancy
// counter; pointers wrap naturally.
module word_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/word_assembler.sv
// Packs RATIO narrow beats into one wide word
// with partial flush and a decoupling queue.
module word_assembler
  import instr_load_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int DEPTH     = 2
) (
  input  logic       clk,
  input  logic       rst,
  word_assembler_if.slave bus
);

  localparam int OUT_W = out_w(IN_W, RATIO);
  localparam int CW    = cnt_w(RATIO);
  localparam int EW    = OUT_W + RATIO;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [RATIO-1:0] keep;
  } ent_t;

  logic [OUT_W-1:0]      acc_q;
  logic [OUT_W-1:0]      acc_nxt;
  logic [RATIO-1:0]      keep_q;
  logic [RATIO-1:0]      keep_nxt;
  logic [CW-1:0]         cnt_q;
  logic                  full;
  logic                  empty;
  logic                  in_ready;
  logic                  accept;
  logic                  flush_tk;
  logic                  last;
  logic                  push;
  logic                  pop;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic                  unused_cnt;
  ent_t                  wr_ent;
  ent_t                  rd_ent;

  assign in_ready = !rst && !full;
  assign accept   = bus.in_valid && in_ready;
  assign flush_tk = bus.flush && in_ready;
  assign pop      = !empty && bus.out_ready;
  assign last     = accept && (cnt_q == CW'(RATIO-1));
  assign push     = last ||
                    (flush_tk && (accept || cnt_q != '0));

  // Merge the incoming beat into its lane.
  always_comb begin
    acc_nxt  = acc_q;
    keep_nxt = keep_q;
    for (int l = 0; l < RATIO; l++) begin
      if (accept &&
          cnt_q == CW'(lane_idx(l, RATIO, LSB_FIRST))) begin
        acc_nxt[l*IN_W +: IN_W] = bus.in_data;
        keep_nxt[l]             = 1'b1;
      end
    end
  end

  assign wr_ent = '{data: acc_nxt, keep: keep_nxt};

  // Partial word: clear on push, else absorb beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      keep_q <= '0;
      cnt_q  <= '0;
    end else if (push) begin
      acc_q  <= '0;
      keep_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      acc_q  <= acc_nxt;
      keep_q <= keep_nxt;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  word_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wr_ent),
    .pop   (pop),
    .dout  (rd_ent),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign unused_cnt    = ^fifo_cnt;
  assign bus.in_ready  = in_ready;
  assign bus.out_data  = rd_ent.data;
  assign bus.out_keep  = rd_ent.keep;
  assign bus.out_valid = !empty;
  assign bus.lane_cnt  = cnt_q;

endmodule

// File: tb/tb_word_assembler.sv
// Bench for word_assembler: both lane orders
// side by side against a queue-level model.
module tb_word_assembler;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       flush;
  logic       out_ready;

  always #5 clk = ~clk;

  word_assembler_if #(.IN_W(8), .RATIO(4)) ifa ();
  word_assembler_if #(.IN_W(8), .RATIO(4)) ifb ();

  assign ifa.in_data   = in_data;
  assign ifa.in_valid  = in_valid;
  assign ifa.flush     = flush;
  assign ifa.out_ready = out_ready;
  assign ifb.in_data   = in_data;
  assign ifb.in_valid  = in_valid;
  assign ifb.flush     = flush;
  assign ifb.out_ready = out_ready;

  word_assembler #(
    .IN_W(8), .RATIO(4), .LSB_FIRST(1'b1), .DEPTH(DEPTH)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  word_assembler #(
    .IN_W(8), .RATIO(4), .LSB_FIRST(1'b0), .DEPTH(DEPTH)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
  } ent_t;

  typedef struct {
    int             n;
    logic [3:0][7:0] b;
    bit             fl_last;
    bit             fl_after;
    int             nw;
    logic [31:0]    wa;
    logic [3:0]     ka;
    logic [31:0]    wb;
    logic [3:0]     kb;
  } vec_t;

  ent_t       qa[$];
  ent_t       qb[$];
  ent_t       capa[$];
  ent_t       capb[$];
  logic [7:0] part[$];
  int         checks = 0;
  int         errors = 0;
  bit         last_acc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  function automatic ent_t mk(input bit lsb);
    ent_t e;
    e.d = '0;
    e.k = '0;
    foreach (part[i]) begin
      int ln;
      ln  = lsb ? i : 3 - i;
      e.d = e.d | (32'(part[i]) << (8 * ln));
      e.k = e.k | (4'b0001 << ln);
    end
    return e;
  endfunction

  task automatic cycle();
    bit rdy;
    bit acc;
    bit ft;
    bit pop;
    @(negedge clk);
    rdy = !rst && (qa.size() < DEPTH);
    chk("in_ready_a", 32'(ifa.in_ready), 32'(rdy));
    chk("in_ready_b", 32'(ifb.in_ready), 32'(rdy));
    chk("out_valid_a", 32'(ifa.out_valid),
        32'(qa.size() != 0));
    chk("out_valid_b", 32'(ifb.out_valid),
        32'(qb.size() != 0));
    chk("lane_cnt_a", 32'(ifa.lane_cnt),
        32'(part.size()));
    chk("lane_cnt_b", 32'(ifb.lane_cnt),
        32'(part.size()));
    if (qa.size() != 0) begin
      chk("data_a", ifa.out_data, qa[0].d);
      chk("keep_a", 32'(ifa.out_keep), 32'(qa[0].k));
      chk("data_b", ifb.out_data, qb[0].d);
      chk("keep_b", 32'(ifb.out_keep), 32'(qb[0].k));
    end
    acc = in_valid && rdy;
    ft  = flush && rdy;
    pop = (qa.size() != 0) && out_ready;
    last_acc = acc;
    if (rst) begin
      qa.delete();
      qb.delete();
      part.delete();
    end else begin
      if (pop) begin
        capa.push_back('{ifa.out_data, ifa.out_keep});
        capb.push_back('{ifb.out_data, ifb.out_keep});
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (acc)
        part.push_back(in_data);
      if (part.size() == 4 ||
          (ft && part.size() != 0)) begin
        qa.push_back(mk(1'b1));
        qb.push_back(mk(1'b0));
        part.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 32'(ifa.out_valid), 32'd0);
    chk({nm, "_lane"}, 32'(ifa.lane_cnt), 32'd0);
    chk({nm, "_data"}, ifa.out_data, 32'd0);
    chk({nm, "_keep"}, 32'(ifa.out_keep), 32'd0);
    chk({nm, "_ready"}, 32'(ifa.in_ready), 32'd1);
    chk({nm, "_valid_b"}, 32'(ifb.out_valid), 32'd0);
    chk({nm, "_data_b"}, ifb.out_data, 32'd0);
  endtask

  vec_t vt[6];
  int   nacc;

  initial begin
    vt[0] = '{4, 32'h44332211, 1'b0, 1'b0, 1,
              32'h44332211, 4'hF, 32'h11223344, 4'hF};
    vt[1] = '{2, 32'h0000BBAA, 1'b0, 1'b1, 1,
              32'h0000BBAA, 4'h3, 32'hAABB0000, 4'hC};
    vt[2] = '{0, 32'h0, 1'b0, 1'b1, 0,
              32'h0, 4'h0, 32'h0, 4'h0};
    vt[3] = '{3, 32'h00332211, 1'b1, 1'b0, 1,
              32'h00332211, 4'h7, 32'h11223300, 4'hE};
    vt[4] = '{4, 32'h44332211, 1'b1, 1'b0, 1,
              32'h44332211, 4'hF, 32'h11223344, 4'hF};
    vt[5] = '{1, 32'h0000005A, 1'b1, 1'b0, 1,
              32'h0000005A, 4'h1, 32'h5A000000, 4'h8};

    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    @(posedge clk);
    #1;
    chk("rst_in_ready_a", 32'(ifa.in_ready), 32'd0);
    chk("rst_in_ready_b", 32'(ifb.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_idle("reset");

    for (int i = 0; i < 6; i++) begin
      capa.delete();
      capb.delete();
      out_ready = 1'b1;
      for (int k = 0; k < vt[i].n; k++) begin
        in_data  = vt[i].b[k];
        in_valid = 1'b1;
        flush    = vt[i].fl_last && (k == vt[i].n - 1);
        cycle();
      end
      in_valid = 1'b0;
      flush    = vt[i].fl_after;
      if (vt[i].fl_after)
        cycle();
      flush = 1'b0;
      repeat (3) cycle();
      chk($sformatf("v%0d_nwords_a", i),
          32'(capa.size()), 32'(vt[i].nw));
      chk($sformatf("v%0d_nwords_b", i),
          32'(capb.size()), 32'(vt[i].nw));
      chk($sformatf("v%0d_lane_end", i),
          32'(ifa.lane_cnt), 32'd0);
      if (vt[i].nw == 1) begin
        chk($sformatf("v%0d_word_a", i),
            capa.size() > 0 ? capa[0].d : 32'hx,
            vt[i].wa);
        chk($sformatf("v%0d_keep_a", i),
            32'(capa.size() > 0 ? capa[0].k : 4'hx),
            32'(vt[i].ka));
        chk($sformatf("v%0d_word_b", i),
            capb.size() > 0 ? capb[0].d : 32'hx,
            vt[i].wb);
        chk($sformatf("v%0d_keep_b", i),
            32'(capb.size() > 0 ? capb[0].k : 4'hx),
            32'(vt[i].kb));
      end
    end

    capa.delete();
    capb.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    nacc      = 0;
    for (int c = 0; c < 60 && nacc < 12; c++) begin
      in_data   = 8'(nacc + 1);
      out_ready = (c >= 14);
      if (c == 10)
        chk("bp_in_ready_low",
            32'(ifa.in_ready), 32'd0);
      cycle();
      if (last_acc)
        nacc++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(nacc), 32'd12);
    repeat (6) cycle();
    chk("bp_nwords", 32'(capa.size()), 32'd3);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("bp_word%0d", j),
          capa.size() > j ? capa[j].d : 32'hx,
          32'h04030201 + 32'(j) * 32'h04040404);
    end

    capa.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 8'(k + 16);
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk_idle("midrst");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(k + 1);
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("midrst_nwords", 32'(capa.size()), 32'd1);
    chk("midrst_word",
        capa.size() > 0 ? capa[0].d : 32'hx,
        32'h04030201);

    for (int c = 0; c < 500; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = 8'($urandom);
      flush     = $urandom_range(0, 7) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      rst       = $urandom_range(0, 99) == 0;
      cycle();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
